// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared definitions for the multi-cycle RISC-V control unit.
//   - state_t    : 3-bit FSM state encoding
//   - OPC_*      : opcode values of the supported instruction classes
//   - ALU_OP_*   : alu_op encodings driven to the datapath
//   - MUX*_*     : select values for the four datapath multiplexers
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_FETCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_R      = 2'b10;
  localparam logic [1:0] ALU_OP_I      = 2'b11;

  localparam logic [1:0] MUX1_REG_B   = 2'd0;  // ALU B operand
  localparam logic [1:0] MUX1_IMM     = 2'd1;
  localparam logic [1:0] MUX2_MEM     = 2'd0;  // register write data
  localparam logic [1:0] MUX2_ALU     = 2'd1;
  localparam logic [1:0] MUX3_PC_INC  = 2'd0;  // next PC
  localparam logic [1:0] MUX3_PC_IMM  = 2'd1;
  localparam logic [1:0] MUX4_ALU     = 2'd0;  // data memory Din
  localparam logic [1:0] MUX4_REG_B   = 2'd1;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// riscv_ctrl_decode: combinational opcode classifier.
//   opcode      in  7  opcode to classify
//   is_r .. is_branch out 1  one-hot legal class flags
//   is_illegal  out 1  set for any opcode outside the five legal classes
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_r,
  output logic       is_i,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_illegal
);

  always_comb begin
    is_r       = 1'b0;
    is_i       = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_R:      is_r       = 1'b1;
      OPC_I:      is_i       = 1'b1;
      OPC_LOAD:   is_load    = 1'b1;
      OPC_STORE:  is_store   = 1'b1;
      OPC_BRANCH: is_branch  = 1'b1;
      default:    is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_ctrl.sv
// riscv_ctrl: multi-cycle control unit for the RISC-V datapath.
// Sequences each instruction through FETCH/DECODE/EXEC/(MEM)/WB, pauses at
// instruction boundaries when run=0 and halts permanently on illegal opcodes.
//   clk, reset (async, active-low), run, opcode[6:0], branch   inputs
//   pc_load, pc_reset, mem_re, mem_we, reg_file_write          enables
//   alu_op[1:0], select_mux_1..4[1:0]                          datapath selects
//   illegal (sticky), instret[CNT_W-1:0] (retired count)
// Optional: define RISCV_CTRL_INSTRET_EN to build the retired-instruction
// counter; otherwise instret is constant 0.
module riscv_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch,
  output logic             pc_load,
  output logic             pc_reset,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_file_write,
  output logic [1:0]       alu_op,
  output logic [1:0]       select_mux_1,
  output logic [1:0]       select_mux_2,
  output logic [1:0]       select_mux_3,
  output logic [1:0]       select_mux_4,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_t     state_reg, state_next;
  logic [6:0] opcode_reg;
  logic [3:0] cnt_reg, cnt_next;
  logic       illegal_reg;
  logic       retire;

  logic [6:0] dec_opcode;
  logic       is_r, is_i, is_load, is_store, is_branch, is_illegal;

  // DECODE classifies the live opcode; every later state uses the captured one.
  assign dec_opcode = (state_reg == ST_DECODE) ? opcode : opcode_reg;

  riscv_ctrl_decode u_decode (
    .opcode     (dec_opcode),
    .is_r       (is_r),
    .is_i       (is_i),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_INIT;
      opcode_reg  <= '0;
      cnt_reg     <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_DECODE) begin
        opcode_reg <= opcode;
        if (is_illegal) illegal_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    retire         = 1'b0;
    pc_load        = 1'b0;
    pc_reset       = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    reg_file_write = 1'b0;
    alu_op         = ALU_OP_ADD;
    select_mux_1   = MUX1_REG_B;
    select_mux_2   = MUX2_MEM;
    select_mux_3   = MUX3_PC_INC;
    select_mux_4   = MUX4_ALU;

    case (state_reg)
      ST_INIT: begin
        pc_reset   = 1'b1;
        state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (run) state_next = ST_FETCH;
      end
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: state_next = is_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (is_r) begin
          alu_op     = ALU_OP_R;
          state_next = ST_WB;
        end else if (is_i) begin
          alu_op       = ALU_OP_I;
          select_mux_1 = MUX1_IMM;
          state_next   = ST_WB;
        end else if (is_load || is_store) begin
          select_mux_1 = MUX1_IMM;
          cnt_next     = MEM_LAST;
          state_next   = ST_MEM;
        end else if (is_branch) begin
          // Only Mealy output: branch outcome steers the next PC directly.
          alu_op       = ALU_OP_BRANCH;
          pc_load      = 1'b1;
          select_mux_3 = branch ? MUX3_PC_IMM : MUX3_PC_INC;
          retire       = 1'b1;
        end else begin
          state_next = ST_HALT;
        end
      end
      ST_MEM: begin
        // Address path stays valid for every cycle of the access.
        select_mux_1 = MUX1_IMM;
        if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
        if (is_load) begin
          mem_re = 1'b1;
          if (cnt_reg == 4'd0) state_next = ST_WB;
        end else begin
          select_mux_4 = MUX4_REG_B;
          // Counter is still at its load value only in the first MEM cycle.
          mem_we       = (cnt_reg == MEM_LAST);
          if (cnt_reg == 4'd0) begin
            pc_load = 1'b1;
            retire  = 1'b1;
          end
        end
      end
      ST_WB: begin
        reg_file_write = 1'b1;
        pc_load        = 1'b1;
        retire         = 1'b1;
        if (is_load) begin
          select_mux_2 = MUX2_MEM;
        end else begin
          select_mux_2 = MUX2_ALU;
          if (is_r) alu_op = ALU_OP_R;
          if (is_i) begin
            alu_op       = ALU_OP_I;
            select_mux_1 = MUX1_IMM;
          end
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_INIT;
    endcase

    if (retire) state_next = run ? ST_FETCH : ST_IDLE;
  end

  assign illegal = illegal_reg;

`ifdef RISCV_CTRL_INSTRET_EN
  logic [CNT_W-1:0] instret_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_reg <= '0;
    else if (retire) instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign instret = instret_reg;
`else
  assign instret = '0;
`endif

endmodule

// File: doc/riscv_ctrl.md
Name: riscv_ctrl

Overview:
Multi-cycle control unit driving the RISC-V datapath control inputs (PC load/reset, memory enables, register-file write, ALU op, four mux selects) from the datapath's opcode and branch outputs. Splits each instruction into FETCH/DECODE/EXEC/MEM/WB states. Supports a run/pause handshake at instruction boundaries and a configurable data-memory latency. Halts on illegal opcodes.

Parameters:
MEM_LAT, 1, cycles spent in MEM per load/store (1..15); mem_re/address held for all of them.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  1 = execute; sampled in IDLE and at each instruction end
opcode  in  7  instruction opcode from datapath
branch  in  1  branch-taken flag from datapath ALU control
pc_load  out  1  PC register load enable
pc_reset  out  1  PC register clear
mem_re  out  1  data memory read enable
mem_we  out  1  data memory write enable
reg_file_write  out  1  register file write enable
alu_op  out  2  00 add (address), 01 branch compare, 10 R-type funct, 11 I-type funct
select_mux_1  out  2  ALU B: 0 reg_b, 1 immediate
select_mux_2  out  2  reg write data: 0 mem_out, 1 alu_out
select_mux_3  out  2  next PC: 0 pc+1, 1 pc+imm
select_mux_4  out  2  mem Din: 0 alu_out, 1 reg_b
illegal  out  1  sticky illegal-opcode flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: INIT, IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs are Moore decodes of state and opcode_q. The only Mealy term is select_mux_3 in EXEC for branches.
- Reset (reset=0, async): state=INIT, opcode_q=0, mem counter=0, illegal=0, instret=0. All outputs 0 except pc_reset, which is 1 in INIT.
- INIT: pc_reset=1 for exactly one cycle after reset release -> IDLE.
- IDLE: all enables 0. run=1 -> FETCH, else stay.
- FETCH: all enables 0; one cycle for the instruction memory read -> DECODE.
- DECODE: capture opcode into opcode_q.
  - Legal classes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011 -> EXEC.
  - Any other opcode -> HALT.
- EXEC, by class:
  - R: alu_op=10, mux_1=0 -> WB.
  - I: alu_op=11, mux_1=1 -> WB.
  - LOAD/STORE: alu_op=00, mux_1=1; counter loaded with MEM_LAT-1 -> MEM.
  - BRANCH: alu_op=01, mux_1=0, pc_load=1, mux_3=branch (taken -> pc+imm, else pc+1); retires.
- MEM: alu_op=00, mux_1=1 held every cycle; counter decrements.
  - LOAD: mem_re=1 every MEM cycle; counter=0 -> WB.
  - STORE: mem_we=1 in the first MEM cycle only; mux_4=1 in all MEM cycles. Counter=0 -> pc_load=1, mux_3=0; retires.
- WB: reg_file_write=1 and pc_load=1, mux_3=0; retires.
  - LOAD: mux_2=0.
  - R/I: mux_2=1, ALU controls of the class held.
- Retire (last cycle of an instruction): next state is FETCH if run=1, else IDLE. PC is not reset when pausing.
- HALT: illegal=1, all enables 0. Exits only via reset; run is ignored.
- Exactly one pc_load pulse per instruction. mem_we is never asserted together with reg_file_write.
- Reset mid-instruction: immediate return to INIT, so no partial write completes after reset assertion.
- MEM_LAT=1: MEM lasts one cycle. Counter width is 4 bits.

Optional Feature:
RISCV_CTRL_INSTRET_EN:
- Defined: instret increments (wrapping modulo 2^CNT_W) on every retire cycle; cleared by reset only.
- Undefined: counter logic is absent and instret is driven constant 0.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encoding (3-bit);
  - opcode constants OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH;
  - alu_op encodings;
  - mux select constants.
- One sub-module, riscv_ctrl_decode: combinational opcode -> one-hot class {r, i, load, store, branch, illegal}, used by DECODE.

Test Plan:
- Reset then run=1, opcode=0110011 -> pc_reset=1 one cycle. Then FETCH, DECODE, EXEC (alu_op=10), WB (reg_file_write=1, mux_2=1, pc_load=1). instret=1 with macro.
- LOAD 0000011 with MEM_LAT=3 -> mem_re=1 for 3 consecutive cycles with alu_op=00, mux_1=1. Then WB with mux_2=0, reg_file_write=1. Total 7 cycles FETCH to retire.
- STORE 0100011, MEM_LAT=3 -> mem_we=1 in first MEM cycle only, mux_4=1 throughout. reg_file_write never 1. pc_load on last MEM cycle.
- BRANCH 1100011 with branch=1 -> EXEC shows pc_load=1, mux_3=1. Repeat with branch=0 -> mux_3=0. Each takes 3 cycles.
- run dropped during an R-type EXEC -> instruction completes, FSM goes IDLE with pc_reset=0. Raising run resumes at FETCH.
- opcode=1111111 -> HALT, illegal=1, all enables 0 for 20 cycles despite run=1. reset=0 mid-MEM of a store -> mem_we drops immediately, state=INIT.
